pipeline_stall_controller: RTL and testbench

PIPELINE_STALL_CONTROLLER -- requirements
Module: pipeline_stall_controller

---
 rtl/mips_pkg.sv | 18 +
 rtl/pipeline_stall_controller_if.sv | 41 ++++
 rtl/pipeline_stall_controller_md_latency_counter.sv | 34 +++
 rtl/pipeline_stall_controller.sv | 122 ++++++++++++
 tb/tb_pipeline_stall_controller.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mips_pkg : shared types and constants for the stall controller.      |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package mips_pkg;

    localparam int c_DEFAULT_MUL_CYCLES = 4;
    localparam int c_DEFAULT_DIV_CYCLES = 32;
    localparam int c_CNT_W              = 6;

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

endpackage
`default_nettype wire

// File: rtl/pipeline_stall_controller_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipeline_stall_controller_if : ID/EX hazard inputs and the pipeline  |
// | control outputs. Revision : 1.0                                      |
// +----------------------------------------------------------------------+
interface pipeline_stall_controller_if;

    logic [4:0]  i_id_rs;
    logic [4:0]  i_id_rt;
    logic        i_id_uses_rt;
    logic        i_id_uses_hilo;
    logic        i_id_md_op;
    logic        i_id_md_div;
    logic [4:0]  i_ex_rd;
    logic        i_ex_memRead;
    logic        i_ex_branch_taken;
    logic        i_ex_jump;
    logic        o_pc_en;
    logic        o_ifid_en;
    logic        o_ifid_flush;
    logic        o_idex_flush;
    logic        o_md_start;
    logic        o_md_busy;
    logic [15:0] o_stall_cnt;

    modport slave (
        input  i_id_rs, i_id_rt, i_id_uses_rt, i_id_uses_hilo, i_id_md_op,
               i_id_md_div, i_ex_rd, i_ex_memRead, i_ex_branch_taken, i_ex_jump,
        output o_pc_en, o_ifid_en, o_ifid_flush, o_idex_flush, o_md_start,
               o_md_busy, o_stall_cnt
    );

    modport master (
        output i_id_rs, i_id_rt, i_id_uses_rt, i_id_uses_hilo, i_id_md_op,
               i_id_md_div, i_ex_rd, i_ex_memRead, i_ex_branch_taken, i_ex_jump,
        input  o_pc_en, o_ifid_en, o_ifid_flush, o_idex_flush, o_md_start,
               o_md_busy, o_stall_cnt
    );

endinterface
`default_nettype wire

// File: rtl/pipeline_stall_controller_md_latency_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | md_latency_counter : loadable down-counter timing the HI/LO unit.    |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module md_latency_counter
    import mips_pkg::*;
#(
    parameter int CNT_W = c_CNT_W
) (
    input  wire logic             i_clk,
    input  wire logic             i_rst_n,
    input  wire logic             i_load,
    input  wire logic [CNT_W-1:0] i_load_value,
    input  wire logic             i_dec,
    output logic                  o_last
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_last = (r_count == CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/pipeline_stall_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipeline_stall_controller : load-use / HI-LO hazard stalls, redirect |
// | flushes and mult/div latency tracking. Revision : 1.0                |
// +----------------------------------------------------------------------+
module pipeline_stall_controller
    import mips_pkg::*;
#(
    parameter int MUL_CYCLES = c_DEFAULT_MUL_CYCLES,
    parameter int DIV_CYCLES = c_DEFAULT_DIV_CYCLES
) (
    input  wire logic              i_clk,
    input  wire logic              i_rst_n,
    pipeline_stall_controller_if.slave bus
);

    localparam logic [c_CNT_W-1:0] c_MUL_LOAD = c_CNT_W'(MUL_CYCLES);
    localparam logic [c_CNT_W-1:0] c_DIV_LOAD = c_CNT_W'(DIV_CYCLES);

    md_state_t   r_state;
    md_state_t   w_state_next;
    logic [15:0] r_stall_cnt;
    logic        w_lu;
    logic        w_rd;
    logic        w_mh;
    logic        w_busy;
    logic        w_last;
    logic        w_load;
    logic        w_dec;
    logic        w_pc_en;
    logic        w_ifid_en;
    logic        w_ifid_flush;
    logic        w_idex_flush;
    logic        w_md_start;

    assign w_lu = bus.i_ex_memRead && (bus.i_ex_rd != 5'd0) &&
                  ((bus.i_ex_rd == bus.i_id_rs) ||
                   (bus.i_id_uses_rt && (bus.i_ex_rd == bus.i_id_rt)));
    assign w_rd   = bus.i_ex_branch_taken || bus.i_ex_jump;
    assign w_busy = (r_state == MD_BUSY);
    assign w_mh   = w_busy && (bus.i_id_uses_hilo || bus.i_id_md_op);

    always_comb begin
        w_pc_en      = 1'b1;
        w_ifid_en    = 1'b1;
        w_ifid_flush = 1'b0;
        w_idex_flush = 1'b0;
        w_md_start   = 1'b0;
        w_load       = 1'b0;
        w_dec        = 1'b0;
        w_state_next = r_state;
        if (!i_rst_n) begin
            w_pc_en      = 1'b0;
            w_ifid_en    = 1'b0;
            w_ifid_flush = 1'b1;
            w_idex_flush = 1'b1;
        end else begin
            if (w_rd) begin
                w_ifid_flush = 1'b1;
                w_idex_flush = 1'b1;
            end else if (w_mh || w_lu) begin
                w_pc_en      = 1'b0;
                w_ifid_en    = 1'b0;
                w_idex_flush = 1'b1;
            end
            // A redirect never aborts an operation already in flight.
            case (r_state)
                RUN: begin
                    if (bus.i_id_md_op && !w_rd && !w_lu) begin
                        w_md_start   = 1'b1;
                        w_load       = 1'b1;
                        w_state_next = MD_BUSY;
                    end
                end
                MD_BUSY: begin
                    w_dec = 1'b1;
                    if (w_last) begin
                        w_state_next = RUN;
                    end
                end
                default: w_state_next = RUN;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_stall_cnt <= '0;
        end else if (!w_pc_en && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    md_latency_counter #(
        .CNT_W (c_CNT_W)
    ) u_md_latency_counter (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_load       (w_load),
        .i_load_value (bus.i_id_md_div ? c_DIV_LOAD : c_MUL_LOAD),
        .i_dec        (w_dec),
        .o_last       (w_last)
    );

    assign bus.o_pc_en      = w_pc_en;
    assign bus.o_ifid_en    = w_ifid_en;
    assign bus.o_ifid_flush = w_ifid_flush;
    assign bus.o_idex_flush = w_idex_flush;
    assign bus.o_md_start   = w_md_start;
    assign bus.o_md_busy    = w_busy && i_rst_n;
    assign bus.o_stall_cnt  = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_stall_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pipeline_stall_controller : directed + random bench with a        |
// | cycle-level reference model. Revision : 1.0                          |
// +----------------------------------------------------------------------+
module tb_pipeline_stall_controller;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    int   cyc;

    // reference model state: remaining busy cycles and stall count
    int   m_rem;
    int   m_cnt;

    logic        s_pc_en, s_ifid_en, s_ifid_flush, s_idex_flush, s_md_start, s_md_busy;
    logic [15:0] s_stall_cnt;

    pipeline_stall_controller_if bus ();

    pipeline_stall_controller #(
        .MUL_CYCLES (4),
        .DIV_CYCLES (32)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d act=%0d exp=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.i_id_rs = 5'd0; bus.i_id_rt = 5'd0; bus.i_id_uses_rt = 1'b0;
        bus.i_id_uses_hilo = 1'b0; bus.i_id_md_op = 1'b0; bus.i_id_md_div = 1'b0;
        bus.i_ex_rd = 5'd0; bus.i_ex_memRead = 1'b0;
        bus.i_ex_branch_taken = 1'b0; bus.i_ex_jump = 1'b0;
    endtask

    // One clock: compare against the model mid-cycle, then advance the model.
    task automatic tick();
        logic       busy, lu, rd, mh, start;
        logic [5:0] exp_v, act_v;
        @(negedge clk);
        busy  = rst_n && (m_rem > 0);
        lu    = bus.i_ex_memRead && (bus.i_ex_rd != 0) &&
                ((bus.i_ex_rd == bus.i_id_rs) || (bus.i_id_uses_rt && (bus.i_ex_rd == bus.i_id_rt)));
        rd    = bus.i_ex_branch_taken || bus.i_ex_jump;
        mh    = busy && (bus.i_id_uses_hilo || bus.i_id_md_op);
        start = 1'b0;
        if (!rst_n)          exp_v = 6'b001100;
        else if (rd)         exp_v = {5'b11110, busy};
        else if (mh || lu)   exp_v = {5'b00010, busy};
        else begin
            start = bus.i_id_md_op && !busy;
            exp_v = {4'b1100, start, busy};
        end
        act_v = {bus.o_pc_en, bus.o_ifid_en, bus.o_ifid_flush, bus.o_idex_flush,
                 bus.o_md_start, bus.o_md_busy};
        n_checks++;
        if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL outputs cycle=%0d act=%b exp=%b (pc,ifid,fl_ifid,fl_idex,start,busy)",
                     cyc, act_v, exp_v);
        end
        n_checks++;
        if (bus.o_stall_cnt !== 16'(m_cnt)) begin
            n_fail++;
            $display("FAIL stall_cnt cycle=%0d act=%0d exp=%0d", cyc, bus.o_stall_cnt, m_cnt);
        end
        {s_pc_en, s_ifid_en, s_ifid_flush, s_idex_flush, s_md_start, s_md_busy} = act_v;
        s_stall_cnt = bus.o_stall_cnt;
        @(posedge clk);
        if (!rst_n) begin
            m_rem = 0;
            m_cnt = 0;
        end else begin
            if (m_rem > 0)  m_rem = m_rem - 1;
            else if (start) m_rem = bus.i_id_md_div ? 32 : 4;
            if (!exp_v[5] && m_cnt < 65535) m_cnt = m_cnt + 1;
        end
        cyc++;
        #1;
    endtask

    initial begin
        int stalls, busy_seen;
        n_checks = 0; n_fail = 0; cyc = 0; m_rem = 0; m_cnt = 0;
        rst_n = 1'b0;
        clear_inputs();

        // reset
        repeat (3) tick();
        check("rst_pc_en", s_pc_en, 0);
        check("rst_ifid_flush", s_ifid_flush, 1);
        check("rst_stall_cnt", s_stall_cnt, 0);
        rst_n = 1'b1;
        tick();
        check("idle_pc_en", s_pc_en, 1);

        // load-use on r5
        bus.i_ex_memRead = 1'b1; bus.i_ex_rd = 5'd5; bus.i_id_rs = 5'd5;
        tick();
        check("lu_pc_en", s_pc_en, 0);
        check("lu_idex_flush", s_idex_flush, 1);
        clear_inputs();
        tick();
        check("lu_stall_cnt", s_stall_cnt, 1);

        // $zero is never a hazard
        bus.i_ex_memRead = 1'b1; bus.i_ex_rd = 5'd0; bus.i_id_rs = 5'd0;
        tick();
        check("zero_pc_en", s_pc_en, 1);
        clear_inputs();

        // multiply then mflo waiting on it
        bus.i_id_md_op = 1'b1;
        tick();
        check("mul_start", s_md_start, 1);
        clear_inputs();
        bus.i_id_uses_hilo = 1'b1;
        stalls = 0; busy_seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (s_md_busy) busy_seen++;
            if (s_md_start) check("mul_extra_start", 1, 0);
            if (s_pc_en) break;
            stalls++;
        end
        check("mul_stalls", stalls, 4);
        check("mul_busy_cycles", busy_seen, 4);
        check("mflo_issue_pc_en", s_pc_en, 1);
        clear_inputs();

        // priority: redirect beats load-use and launch
        bus.i_ex_memRead = 1'b1; bus.i_ex_rd = 5'd5; bus.i_id_rs = 5'd5; bus.i_ex_branch_taken = 1'b1;
        tick();
        check("pri_lu_pc_en", s_pc_en, 1);
        check("pri_lu_ifid_flush", s_ifid_flush, 1);
        check("pri_lu_stall_cnt", s_stall_cnt, 5);
        clear_inputs();
        bus.i_id_md_op = 1'b1; bus.i_ex_jump = 1'b1;
        tick();
        check("pri_md_start", s_md_start, 0);
        clear_inputs();
        tick();
        check("pri_md_busy", s_md_busy, 0);
        check("pri_stall_cnt", s_stall_cnt, 5);

        // divide abandoned by reset in busy cycle 10
        bus.i_id_md_op = 1'b1; bus.i_id_md_div = 1'b1;
        tick();
        check("div_start", s_md_start, 1);
        clear_inputs();
        repeat (9) tick();
        check("div_busy_c9", s_md_busy, 1);
        rst_n = 1'b0;
        tick();
        check("div_rst_busy", s_md_busy, 0);
        rst_n = 1'b1;
        tick();
        check("div_after_busy", s_md_busy, 0);
        check("div_after_cnt", s_stall_cnt, 0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            rst_n                 = ($urandom_range(0, 99) >= 1);
            bus.i_id_rs           = 5'($urandom_range(0, 3));
            bus.i_id_rt           = 5'($urandom_range(0, 3));
            bus.i_ex_rd           = 5'($urandom_range(0, 3));
            bus.i_id_uses_rt      = ($urandom_range(0, 1) == 1);
            bus.i_ex_memRead      = ($urandom_range(0, 99) < 30);
            bus.i_id_uses_hilo    = ($urandom_range(0, 99) < 15);
            bus.i_id_md_op        = ($urandom_range(0, 99) < 10);
            bus.i_id_md_div       = ($urandom_range(0, 1) == 1);
            bus.i_ex_branch_taken = ($urandom_range(0, 99) < 10);
            bus.i_ex_jump         = ($urandom_range(0, 99) < 5);
            tick();
        end

        // saturation
        clear_inputs();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bus.i_ex_memRead = 1'b1; bus.i_ex_rd = 5'd5; bus.i_id_rs = 5'd5;
        repeat (70000) tick();
        check("sat_stall_cnt", s_stall_cnt, 65535);
        check("sat_pc_en", s_pc_en, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
